// File: rtl/ctrl_ajuste_if.sv
// Bundle between the mode controller and the clock datapath/buttons.
interface ctrl_ajuste_if;
    logic       ctla_tick_1hz;
    logic       ctla_min_tick;
    logic       ctla_hora_carry;
    logic       ctla_btn_modo;
    logic       ctla_btn_inc;
    logic       ctla_btn_inc_nivel;
    logic       ctla_enable_s;
    logic       ctla_enable_m;
    logic       ctla_incremento_m;
    logic       ctla_incremento_h;
    logic [1:0] ctla_modo;
    logic       ctla_pisca;
    logic       ctla_seg_clr;

    modport master (
        output ctla_tick_1hz, ctla_min_tick, ctla_hora_carry,
        output ctla_btn_modo, ctla_btn_inc, ctla_btn_inc_nivel,
        input  ctla_enable_s, ctla_enable_m, ctla_incremento_m,
        input  ctla_incremento_h, ctla_modo, ctla_pisca, ctla_seg_clr
    );

    modport slave (
        input  ctla_tick_1hz, ctla_min_tick, ctla_hora_carry,
        input  ctla_btn_modo, ctla_btn_inc, ctla_btn_inc_nivel,
        output ctla_enable_s, ctla_enable_m, ctla_incremento_m,
        output ctla_incremento_h, ctla_modo, ctla_pisca, ctla_seg_clr
    );
endinterface

// File: rtl/ctrl_ajuste.sv
// RUN / SET_HOUR / SET_MIN mode controller for the HH:MM clock.
// Define CTLA_AUTOREPEAT_EN to enable hold-to-repeat on the increment button.
module ctrl_ajuste #(
    parameter int TIMEOUT_S     = 10,
    parameter int HOLD_CYCLES   = 25000000,
    parameter int REPEAT_CYCLES = 5000000
) (
    input  logic         ctla_clock,
    input  logic         ctla_reset,
    ctrl_ajuste_if.slave bus
);
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2,
        ILLEGAL  = 2'd3
    } state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_S - 1);

    state_t      state_q;
    logic [15:0] tmo_q;
    logic        pisca_q;
    logic        ens_q, enm_q, incm_q, inch_q, segclr_q;
    logic        in_set;
    logic        auto_inc;
    logic        inc;

    assign in_set = (state_q == SET_HOUR) || (state_q == SET_MIN);
    assign inc    = bus.ctla_btn_inc | auto_inc;

`ifdef CTLA_AUTOREPEAT_EN
    logic [31:0] hold_q;
    logic [31:0] rep_q;
    logic        armed_q;
    logic        hold_hit, rep_hit;

    assign hold_hit = !armed_q && (hold_q == 32'(HOLD_CYCLES - 1));
    assign rep_hit  = armed_q && (rep_q == 32'(REPEAT_CYCLES - 1));
    assign auto_inc = in_set && bus.ctla_btn_inc_nivel
                      && !bus.ctla_btn_modo && (hold_hit || rep_hit);

    always_ff @(posedge ctla_clock or posedge ctla_reset) begin
        if (ctla_reset) begin
            hold_q  <= '0;
            rep_q   <= '0;
            armed_q <= 1'b0;
        end else if (!in_set || !bus.ctla_btn_inc_nivel || bus.ctla_btn_modo) begin
            hold_q  <= '0;
            rep_q   <= '0;
            armed_q <= 1'b0;
        end else if (hold_hit) begin
            armed_q <= 1'b1;
            rep_q   <= '0;
        end else if (!armed_q) begin
            hold_q <= hold_q + 32'd1;
        end else begin
            rep_q <= rep_hit ? '0 : rep_q + 32'd1;
        end
    end
`else
    assign auto_inc = 1'b0;
`endif

    always_ff @(posedge ctla_clock or posedge ctla_reset) begin
        if (ctla_reset) begin
            state_q  <= RUN;
            tmo_q    <= '0;
            pisca_q  <= 1'b0;
            ens_q    <= 1'b0;
            enm_q    <= 1'b0;
            incm_q   <= 1'b0;
            inch_q   <= 1'b0;
            segclr_q <= 1'b0;
        end else begin
            ens_q    <= 1'b0;
            enm_q    <= 1'b0;
            incm_q   <= 1'b0;
            inch_q   <= 1'b0;
            segclr_q <= 1'b0;
            case (state_q)
                RUN: begin
                    ens_q   <= bus.ctla_tick_1hz;
                    enm_q   <= bus.ctla_tick_1hz;
                    incm_q  <= bus.ctla_min_tick;
                    inch_q  <= bus.ctla_tick_1hz & bus.ctla_hora_carry;
                    pisca_q <= 1'b0;
                    tmo_q   <= '0;
                    if (bus.ctla_btn_modo) begin
                        state_q <= SET_HOUR;
                        pisca_q <= 1'b1;
                    end
                end
                SET_HOUR, SET_MIN: begin
                    if (bus.ctla_btn_modo) begin
                        // Mode change wins over a coincident increment
                        tmo_q    <= '0;
                        state_q  <= (state_q == SET_HOUR) ? SET_MIN : RUN;
                        pisca_q  <= (state_q == SET_HOUR);
                        segclr_q <= (state_q == SET_MIN);
                    end else begin
                        if (bus.ctla_tick_1hz)
                            pisca_q <= ~pisca_q;
                        if (inc) begin
                            tmo_q <= '0;
                            if (state_q == SET_HOUR) begin
                                inch_q <= 1'b1;
                            end else begin
                                enm_q  <= 1'b1;
                                incm_q <= 1'b1;
                            end
                        end else if (bus.ctla_tick_1hz) begin
                            if (tmo_q >= TMO_LAST) begin
                                tmo_q    <= '0;
                                state_q  <= RUN;
                                pisca_q  <= 1'b0;
                                segclr_q <= 1'b1;
                            end else begin
                                tmo_q <= tmo_q + 16'd1;
                            end
                        end
                    end
                end
                default: begin
                    state_q <= RUN;
                    pisca_q <= 1'b0;
                    tmo_q   <= '0;
                end
            endcase
        end
    end

    assign bus.ctla_enable_s     = ens_q;
    assign bus.ctla_enable_m     = enm_q;
    assign bus.ctla_incremento_m = incm_q;
    assign bus.ctla_incremento_h = inch_q;
    assign bus.ctla_modo         = state_q;
    assign bus.ctla_pisca        = pisca_q;
    assign bus.ctla_seg_clr      = segclr_q;
endmodule

// File: tb/tb_ctrl_ajuste.sv
// Scoreboard bench for ctrl_ajuste: directed steps push expected outputs,
// a monitor pops and compares them on the falling edge.
module tb_ctrl_ajuste;
    logic clk = 1'b0;
    logic rst = 1'b1;

    ctrl_ajuste_if bus();

    ctrl_ajuste #(
        .TIMEOUT_S    (3),
        .HOLD_CYCLES  (8),
        .REPEAT_CYCLES(4)
    ) dut (
        .ctla_clock(clk),
        .ctla_reset(rst),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] e;
        int         id;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   step_id = 0;

    // {enable_s, enable_m, incremento_m, incremento_h, modo[1:0], pisca, seg_clr}
    function automatic logic [7:0] outs();
        return {bus.ctla_enable_s, bus.ctla_enable_m,
                bus.ctla_incremento_m, bus.ctla_incremento_h,
                bus.ctla_modo, bus.ctla_pisca, bus.ctla_seg_clr};
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t x;
            logic [7:0] a;
            x = exp_q.pop_front();
            a = outs();
            n_total++;
            if (a === x.e)
                n_pass++;
            else
                $display("FAIL step%0d: got %b expected %b", x.id, a, x.e);
        end
    end

    task automatic step(input logic r, input logic m, input logic i,
                        input logic t, input logic mt, input logic hc,
                        input logic lv, input logic [7:0] e);
        exp_t x;
        rst                    = r;
        bus.ctla_btn_modo      = m;
        bus.ctla_btn_inc       = i;
        bus.ctla_tick_1hz      = t;
        bus.ctla_min_tick      = mt;
        bus.ctla_hora_carry    = hc;
        bus.ctla_btn_inc_nivel = lv;
        @(posedge clk);
        #1;
        x.e  = e;
        x.id = step_id;
        exp_q.push_back(x);
        step_id++;
        @(negedge clk);
    endtask

    initial begin
        bus.ctla_btn_modo      = 1'b0;
        bus.ctla_btn_inc       = 1'b0;
        bus.ctla_tick_1hz      = 1'b0;
        bus.ctla_min_tick      = 1'b0;
        bus.ctla_hora_carry    = 1'b0;
        bus.ctla_btn_inc_nivel = 1'b0;
        @(negedge clk);
        // reset state
        step(1, 0,0,0,0,0,0, 8'b0000_0000);
        // RUN forwarding; buttons other than modo do nothing
        step(0, 0,0,1,1,0,0, 8'b1110_0000);
        step(0, 0,0,1,0,1,0, 8'b1101_0000);
        step(0, 0,0,0,0,1,0, 8'b0000_0000);
        step(0, 0,1,0,0,0,0, 8'b0000_0000);
        // SET_HOUR with three increments
        step(0, 1,0,0,0,0,0, 8'b0000_0110);
        step(0, 0,1,0,0,0,0, 8'b0001_0110);
        step(0, 0,0,0,0,0,0, 8'b0000_0110);
        step(0, 0,1,0,0,0,0, 8'b0001_0110);
        step(0, 0,1,0,0,0,0, 8'b0001_0110);
        step(0, 0,0,0,0,0,0, 8'b0000_0110);
        step(0, 0,0,1,1,1,0, 8'b0000_0100);
        // modo + inc together: mode wins
        step(0, 1,1,0,0,0,0, 8'b0000_1010);
        // SET_MIN: carry ignored, blink toggles, one minute increment
        step(0, 0,0,1,0,1,0, 8'b0000_1000);
        step(0, 0,0,1,0,1,0, 8'b0000_1010);
        step(0, 0,1,0,0,1,0, 8'b0110_1010);
        step(0, 0,0,0,0,0,0, 8'b0000_1010);
        // async reset mid-SET_MIN
        step(1, 0,0,0,0,0,0, 8'b0000_0000);
        step(0, 0,0,1,1,0,0, 8'b1110_0000);
        // full mode cycle, seg_clr on exit
        step(0, 1,0,0,0,0,0, 8'b0000_0110);
        step(0, 1,0,0,0,0,0, 8'b0000_1010);
        step(0, 1,0,0,0,0,0, 8'b0000_0001);
        step(0, 0,0,0,0,0,0, 8'b0000_0000);
        // timeout after 3 ticks
        step(0, 1,0,0,0,0,0, 8'b0000_0110);
        step(0, 0,0,1,0,0,0, 8'b0000_0100);
        step(0, 0,0,1,0,0,0, 8'b0000_0110);
        step(0, 0,0,1,0,0,0, 8'b0000_0001);
        step(0, 0,0,0,0,0,0, 8'b0000_0000);
        // timeout tick coinciding with inc: button wins
        step(0, 1,0,0,0,0,0, 8'b0000_0110);
        step(0, 0,0,1,0,0,0, 8'b0000_0100);
        step(0, 0,0,1,0,0,0, 8'b0000_0110);
        step(0, 0,1,1,0,0,0, 8'b0001_0100);
        step(0, 0,0,1,0,0,0, 8'b0000_0110);
        step(0, 1,0,0,0,0,0, 8'b0000_1010);
        // held level in SET_MIN
        for (int k = 1; k <= 20; k++) begin
`ifdef CTLA_AUTOREPEAT_EN
            if (k == 8 || k == 12 || k == 16 || k == 20)
                step(0, 0,0,0,0,0,1, 8'b0110_1010);
            else
                step(0, 0,0,0,0,0,1, 8'b0000_1010);
`else
            step(0, 0,0,0,0,0,1, 8'b0000_1010);
`endif
        end
        for (int k = 0; k < 4; k++)
            step(0, 0,0,0,0,0,0, 8'b0000_1010);
        step(0, 1,0,0,0,0,0, 8'b0000_0001);
        step(0, 0,0,0,0,0,0, 8'b0000_0000);

        for (int k = 0; k < 10 && exp_q.size() > 0; k++)
            @(negedge clk);
        if (exp_q.size() > 0) begin
            n_total++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
